// File: rtl/note_pkg.sv
// note_pkg: shared definitions for the note_player tone generator.
//   HALF_PERIOD : square-wave half-period in 100 MHz clock cycles for
//                 note codes 0..12 (0 = rest, 1..12 = C4..B4)
//   state_t     : note_player FSM states (GAP only with NOTE_PLAYER_GAP_EN)
//   GAP_TICKS   : length of the silent inter-note gap, in duration ticks
//   half_period : code/octave to half-period lookup; codes 13..15 give 0 (rest)
package note_pkg;

  localparam int GAP_TICKS = 8;

  localparam logic [17:0] HALF_PERIOD [13] = '{
    18'd0,      18'd191113, 18'd180388, 18'd170262, 18'd160706,
    18'd151686, 18'd143173, 18'd135137, 18'd127553, 18'd120394,
    18'd113636, 18'd107258, 18'd101238
  };

`ifdef NOTE_PLAYER_GAP_EN
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, PLAY} state_t;
`endif

  // A zero half-period means "rest": the tone counter never runs.
  function automatic logic [17:0] half_period(input logic [3:0] code,
                                              input logic [1:0] oct);
    if (code > 4'd12) return '0;
    return HALF_PERIOD[code] >> oct;
  endfunction

endpackage

// File: rtl/note_player_tick_gen.sv
// tick_gen: TICK_DIV prescaler for the note duration timer.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear; holds the prescaler at zero
//   tick       : one-cycle strobe every TICK_DIV cycles after clear drops
module tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || cnt == CW'(TICK_DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = !clear && (cnt == CW'(TICK_DIV - 1));

endmodule

// File: rtl/note_player.sv
// note_player: plays one note request at a time as a square wave.
//   clk, rst_n  : 100 MHz clock, asynchronous active-low reset
//   note_valid  : request present; accepted when note_ready is also high
//   note_ready  : block is idle and can accept a request
//   note_code   : 0 / 13..15 = rest, 1..12 = C4..B4
//   note_oct    : octave up-shift (half-period >> note_oct)
//   note_dur    : note length in ticks of TICK_DIV cycles
//   speaker     : square-wave output, 0 whenever not sounding
//   busy        : note or rest in progress
//   done        : one-cycle pulse when a request completes
// Optional feature macro NOTE_PLAYER_GAP_EN: adds a silent GAP_TICKS-tick
// gap after every non-zero-length note before done/note_ready.
module note_player
  import note_pkg::*;
#(
  parameter int TICK_DIV = 100000,
  parameter int DUR_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             note_valid,
  output logic             note_ready,
  input  logic [3:0]       note_code,
  input  logic [1:0]       note_oct,
  input  logic [DUR_W-1:0] note_dur,
  output logic             speaker,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [DUR_W-1:0] dur_cnt;
  logic [17:0]      half;
  logic [17:0]      tone_cnt;
  logic             tick;
  logic             tick_clear;
`ifdef NOTE_PLAYER_GAP_EN
  logic [3:0]       gap_cnt;
`endif

  // The prescaler is held at zero while idle, so the first tick lands
  // exactly TICK_DIV cycles after PLAY entry.
  assign tick_clear = (state == IDLE);

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (tick_clear),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      note_ready <= 1'b0;
      speaker    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dur_cnt    <= '0;
      half       <= '0;
      tone_cnt   <= '0;
`ifdef NOTE_PLAYER_GAP_EN
      gap_cnt    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          speaker    <= 1'b0;
          busy       <= 1'b0;
          note_ready <= 1'b1;
          if (note_valid && note_ready) begin
            half     <= half_period(note_code, note_oct);
            tone_cnt <= '0;
            dur_cnt  <= note_dur;
            // A zero-length request completes immediately without playing.
            if (note_dur == '0) begin
              done <= 1'b1;
            end else begin
              state      <= PLAY;
              busy       <= 1'b1;
              note_ready <= 1'b0;
            end
          end
        end

        PLAY: begin
          if (tick && dur_cnt == DUR_W'(1)) begin
            speaker  <= 1'b0;
            tone_cnt <= '0;
`ifdef NOTE_PLAYER_GAP_EN
            state    <= GAP;
            gap_cnt  <= 4'(GAP_TICKS);
`else
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b1;
            note_ready <= 1'b1;
`endif
          end else begin
            if (tick) begin
              dur_cnt <= dur_cnt - DUR_W'(1);
            end
            // Rests have a zero half-period and keep speaker low.
            if (half != '0) begin
              if (tone_cnt == half - 18'd1) begin
                tone_cnt <= '0;
                speaker  <= ~speaker;
              end else begin
                tone_cnt <= tone_cnt + 18'd1;
              end
            end
          end
        end

`ifdef NOTE_PLAYER_GAP_EN
        GAP: begin
          speaker <= 1'b0;
          if (tick) begin
            if (gap_cnt == 4'd1) begin
              state      <= IDLE;
              busy       <= 1'b0;
              done       <= 1'b1;
              note_ready <= 1'b1;
            end else begin
              gap_cnt <= gap_cnt - 4'd1;
            end
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_player.sv
// tb_note_player: self-checking bench for note_player.
// Runs with a shortened TICK_DIV so whole notes fit in a short simulation.
// Honours NOTE_PLAYER_GAP_EN the same way as the design.
module tb_note_player;

  localparam int TB_TICK = 100;
  localparam int DUR_W   = 16;
`ifdef NOTE_PLAYER_GAP_EN
  localparam int GAP_EXTRA = 8 * TB_TICK;
`else
  localparam int GAP_EXTRA = 0;
`endif

  logic             clk;
  logic             rst_n;
  logic             note_valid;
  logic             note_ready;
  logic [3:0]       note_code;
  logic [1:0]       note_oct;
  logic [DUR_W-1:0] note_dur;
  logic             speaker;
  logic             busy;
  logic             done;

  int checks;
  int errors;
  int hp [16];

  typedef struct {
    logic [3:0] code;
    logic [1:0] oct;
    int         dur;
    int         exp_rises;
    int         exp_lat;
  } vec_t;

  vec_t vecs [7];

  note_player #(.TICK_DIV(TB_TICK), .DUR_W(DUR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .note_code  (note_code),
    .note_oct   (note_oct),
    .note_dur   (note_dur),
    .speaker    (speaker),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  // Sends one request (called at a negedge) and follows it cycle by cycle
  // until its done pulse, comparing against the reference model:
  //   busy cycles = dur*TICK (+ gap), speaker(t) = (t / half) mod 2 while playing.
  task automatic run_note(input logic [3:0] code, input logic [1:0] oct,
                          input int dur, input bit use_exp,
                          input int exp_rises, input int exp_lat,
                          input string name);
    int   h, play_len, total, rises, done_at, bad, wait_cyc, want_lat;
    logic prev, e_spk, e_busy, e_rdy, e_done;
    wait_cyc = 0;
    while (!note_ready && wait_cyc < 1000) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (!note_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s ready_timeout: note_ready still %b, want 1", name, note_ready);
      return;
    end
    h        = hp[code] >> oct;
    play_len = dur * TB_TICK;
    total    = (dur == 0) ? 0 : play_len + GAP_EXTRA;
    note_valid = 1'b1;
    note_code  = code;
    note_oct   = oct;
    note_dur   = DUR_W'(dur);
    @(posedge clk);
    #1;
    note_valid = 1'b0;
    note_code  = 4'($urandom);
    note_oct   = 2'($urandom);
    note_dur   = DUR_W'($urandom);
    rises   = 0;
    done_at = -1;
    bad     = 0;
    prev    = 1'b0;
    for (int n = 1; n <= total + 1; n++) begin
      @(negedge clk);
      if (n <= total) begin
        e_busy = 1'b1; e_rdy = 1'b0; e_done = 1'b0;
        e_spk  = (h != 0 && (n - 1) < play_len) ? 1'(((n - 1) / h) % 2) : 1'b0;
      end else begin
        e_busy = 1'b0; e_rdy = 1'b1; e_done = 1'b1; e_spk = 1'b0;
      end
      if (speaker && !prev) rises++;
      prev = speaker;
      if (done && done_at < 0) done_at = n;
      if ({speaker, busy, note_ready, done} !== {e_spk, e_busy, e_rdy, e_done}) begin
        if (bad == 0)
          $display("[TB] FAIL %s trace cycle %0d: spk/busy/rdy/done got %b%b%b%b want %b%b%b%b",
                   name, n, speaker, busy, note_ready, done, e_spk, e_busy, e_rdy, e_done);
        bad++;
      end
    end
    checks++;
    if (bad != 0) errors++;
    want_lat = use_exp ? exp_lat : total + 1;
    checks++;
    if (done_at != want_lat) begin
      errors++;
      $display("[TB] FAIL %s done_latency: got %0d want %0d", name, done_at, want_lat);
    end
    if (use_exp) begin
      checks++;
      if (rises != exp_rises) begin
        errors++;
        $display("[TB] FAIL %s rises: got %0d want %0d", name, rises, exp_rises);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    hp = '{0, 191113, 180388, 170262, 160706, 151686, 143173, 135137,
           127553, 120394, 113636, 107258, 101238, 0, 0, 0};

    // code, oct, dur, expected rising edges, done cycle after the accept edge
    vecs[0] = '{4'd12, 2'd3, 130, 1, 13001 + GAP_EXTRA};
    vecs[1] = '{4'd0,  2'd0, 2,   0, 201 + GAP_EXTRA};
    vecs[2] = '{4'd5,  2'd0, 0,   0, 1};
    vecs[3] = '{4'd13, 2'd1, 3,   0, 301 + GAP_EXTRA};
    vecs[4] = '{4'd15, 2'd3, 1,   0, 101 + GAP_EXTRA};
    vecs[5] = '{4'd1,  2'd0, 2,   0, 201 + GAP_EXTRA};
    vecs[6] = '{4'd5,  2'd0, 3,   0, 301 + GAP_EXTRA};

    rst_n      = 1'b0;
    note_valid = 1'b0;
    note_code  = '0;
    note_oct   = '0;
    note_dur   = '0;
    repeat (2) @(negedge clk);
    check_bit("reset_ready", note_ready, 1'b0);
    check_bit("reset_speaker", speaker, 1'b0);
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_done", done, 1'b0);
    rst_n = 1'b1;
    #1;
    check_bit("release_ready_before_edge", note_ready, 1'b0);
    @(posedge clk);
    #1;
    check_bit("release_ready_after_edge", note_ready, 1'b1);
    @(negedge clk);

    // Consecutive calls start in the done cycle, so entries 5 and 6 run back to back.
    for (int i = 0; i < 7; i++)
      run_note(vecs[i].code, vecs[i].oct, vecs[i].dur, 1'b1,
               vecs[i].exp_rises, vecs[i].exp_lat, $sformatf("vec%0d", i));

    for (int i = 0; i < 15; i++)
      run_note(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
               $urandom_range(0, 4), 1'b0, 0, 0, $sformatf("rand%0d", i));

    // Reset while a tone is high: outputs must drop before any clock edge.
    run_note_start();
    repeat (12700) @(negedge clk);
    check_bit("midnote_speaker_high", speaker, 1'b1);
    check_bit("midnote_busy", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_bit("midreset_speaker", speaker, 1'b0);
    check_bit("midreset_busy", busy, 1'b0);
    check_bit("midreset_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_bit("midreset_ready_after_edge", note_ready, 1'b1);
    check_bit("midreset_no_done", done, 1'b0);
    @(negedge clk);

    run_note(4'd10, 2'd2, 1, 1'b1, 0, 101 + GAP_EXTRA, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Starts B4 oct 3 for 140 ticks without following it (reset interrupts it).
  task automatic run_note_start();
    int wait_cyc;
    wait_cyc = 0;
    while (!note_ready && wait_cyc < 1000) begin
      @(negedge clk);
      wait_cyc++;
    end
    check_bit("midnote_ready", note_ready, 1'b1);
    note_valid = 1'b1;
    note_code  = 4'd12;
    note_oct   = 2'd3;
    note_dur   = DUR_W'(140);
    @(posedge clk);
    #1;
    note_valid = 1'b0;
  endtask

endmodule
